tanh_pwl_stream: RTL and testbench



---
 rtl/tanh_pwl_pkg.sv | 18 +
 rtl/tanh_pwl_seg_lut.sv | 18 +
 rtl/tanh_pwl_stream.sv | 140 ++++++++++++++
 tb/tb_tanh_pwl_stream.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tanh_pwl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tanh_pwl_pkg : chord tables and mode encoding for the tanh pipeline   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package tanh_pwl_pkg;

    localparam int NUM_SEG = 4;

    localparam logic MODE_PWL  = 1'b0;
    localparam logic MODE_HARD = 1'b1;

    // Unsigned Q0.16; BASE[s+1] = BASE[s] + SLOPE[s] keeps the chords continuous.
    localparam logic [NUM_SEG-1:0][15:0] BASE  = {16'd65212, 16'd63178, 16'd49912, 16'd0};
    localparam logic [NUM_SEG-1:0][15:0] SLOPE = {16'd280, 16'd2034, 16'd13266, 16'd49912};

endpackage
`default_nettype wire

// File: rtl/tanh_pwl_seg_lut.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tanh_pwl_seg_lut : combinational segment -> {base, slope} lookup      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tanh_pwl_seg_lut
    import tanh_pwl_pkg::*;
(
    input  logic [$clog2(NUM_SEG)-1:0] i_seg,
    output logic [15:0]                o_base,
    output logic [15:0]                o_slope
);

    assign o_base  = BASE[i_seg];
    assign o_slope = SLOPE[i_seg];

endmodule
`default_nettype wire

// File: rtl/tanh_pwl_stream.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tanh_pwl_stream : 3-stage streaming tanh (4-chord PWL or hard clamp)  |
// | Optional saturation counter: define TANH_SAT_CNT_EN                   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tanh_pwl_stream
    import tanh_pwl_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] In,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode_i,
    output logic [DATA_W-1:0] Out1,
    output logic              out_valid,
    input  logic              out_ready
`ifdef TANH_SAT_CNT_EN
    ,
    input  logic              sat_clr,
    output logic [15:0]       sat_cnt
`endif
);

    localparam int FRAC_IN  = DATA_W - 3;
    localparam int FRAC_OUT = DATA_W - 1;
    localparam int MAG_W    = DATA_W - 1;
    localparam int PROD_W   = 16 + FRAC_IN;
    localparam int RND_W    = DATA_W + 1;
    localparam logic [MAG_W-1:0]  MAG_MAX  = {MAG_W{1'b1}};
    localparam logic [RND_W-1:0]  RES_MAX  = {2'b00, MAG_MAX};
    localparam logic [17:0]       RND_HALF = 18'd1 << (15 - FRAC_OUT);

    logic              w_en;
    logic [MAG_W-1:0]  w_neg;
    logic [MAG_W-1:0]  w_mag;
    logic [15:0]       w_base;
    logic [15:0]       w_slope;
    logic [PROD_W-1:0] w_prod_full;
    logic [16:0]       w_m16;
    logic [17:0]       w_rsum;
    logic [RND_W-1:0]  w_pwl;
    logic [RND_W-1:0]  w_hard;
    logic [RND_W-1:0]  w_r;
    logic              w_sat;
    logic [DATA_W-1:0] w_res;
    logic [DATA_W-1:0] w_out;

    logic              r_s1_v, r_s1_sign, r_s1_mode;
    logic [MAG_W-1:0]  r_s1_mag;
    logic              r_s2_v, r_s2_sign, r_s2_mode;
    logic [MAG_W-1:0]  r_s2_mag;
    logic [15:0]       r_s2_base;
    logic [15:0]       r_s2_prod;
    logic              r_out_v;
    logic [DATA_W-1:0] r_out;

    // Single global enable: every stage moves together, bubbles included.
    assign w_en      = ~r_out_v | out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_out_v;
    assign Out1      = r_out;

    // S1: magnitude, with -4.0 pinned to the largest positive code.
    assign w_neg = ~In[MAG_W-1:0] + {{(MAG_W-1){1'b0}}, 1'b1};
    assign w_mag = !In[DATA_W-1]                  ? In[MAG_W-1:0] :
                   (In == {1'b1, {MAG_W{1'b0}}}) ? MAG_MAX : w_neg;

    // S2: segment slope times fractional offset.
    tanh_pwl_seg_lut u_lut (
        .i_seg   (r_s1_mag[MAG_W-1 -: 2]),
        .o_base  (w_base),
        .o_slope (w_slope)
    );

    assign w_prod_full = {{FRAC_IN{1'b0}}, w_slope} * {16'd0, r_s1_mag[FRAC_IN-1:0]};

    // S3: chord sum, round half up to FRAC_OUT bits, clamp, restore sign.
    assign w_m16  = {1'b0, r_s2_base} + {1'b0, r_s2_prod};
    assign w_rsum = {1'b0, w_m16} + RND_HALF;
    assign w_pwl  = RND_W'(w_rsum >> (16 - FRAC_OUT));
    assign w_hard = {2'b00, r_s2_mag} << (FRAC_OUT - FRAC_IN);
    assign w_r    = (r_s2_mode == MODE_HARD) ? w_hard : w_pwl;
    assign w_sat  = (w_r > RES_MAX);
    assign w_res  = w_sat ? {1'b0, MAG_MAX} : {1'b0, w_r[MAG_W-1:0]};
    assign w_out  = r_s2_sign ? (~w_res + {{(DATA_W-1){1'b0}}, 1'b1}) : w_res;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_v    <= 1'b0;
            r_s1_sign <= 1'b0;
            r_s1_mode <= 1'b0;
            r_s1_mag  <= '0;
            r_s2_v    <= 1'b0;
            r_s2_sign <= 1'b0;
            r_s2_mode <= 1'b0;
            r_s2_mag  <= '0;
            r_s2_base <= '0;
            r_s2_prod <= '0;
            r_out_v   <= 1'b0;
            r_out     <= '0;
        end else if (w_en) begin
            r_s1_v    <= in_valid;
            r_s1_sign <= In[DATA_W-1];
            r_s1_mode <= mode_i;
            r_s1_mag  <= w_mag;
            r_s2_v    <= r_s1_v;
            r_s2_sign <= r_s1_sign;
            r_s2_mode <= r_s1_mode;
            r_s2_mag  <= r_s1_mag;
            r_s2_base <= w_base;
            r_s2_prod <= 16'(w_prod_full >> FRAC_IN);
            r_out_v   <= r_s2_v;
            if (r_s2_v) begin
                r_out <= w_out;
            end
        end
    end

`ifdef TANH_SAT_CNT_EN
    logic [15:0] r_sat_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sat_cnt <= '0;
        end else if (sat_clr) begin
            r_sat_cnt <= '0;
        end else if (w_en && r_s2_v && w_sat && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign sat_cnt = r_sat_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tanh_pwl_stream.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_tanh_pwl_stream : directed bench for tanh_pwl_stream (DATA_W = 8)  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_tanh_pwl_stream;

    logic       clk;
    logic       reset_n;
    logic [7:0] In;
    logic       in_valid;
    logic       in_ready;
    logic       mode_i;
    logic [7:0] Out1;
    logic       out_valid;
    logic       out_ready;
`ifdef TANH_SAT_CNT_EN
    logic        sat_clr;
    logic [15:0] sat_cnt;
`endif

    int total;
    int bad;

    logic [7:0] s_in   [256];
    logic       s_mode [256];
    logic [7:0] s_exp  [256];
    logic [7:0] cap    [256];

    tanh_pwl_stream #(.DATA_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .In        (In),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode_i    (mode_i),
        .Out1      (Out1),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef TANH_SAT_CNT_EN
        ,
        .sat_clr   (sat_clr),
        .sat_cnt   (sat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Integer reference for DATA_W = 8 (Q2.5 in, Q0.7 out).
    function automatic logic [7:0] ref_tanh(input logic [7:0] x, input logic m);
        int v, mag, seg, frac, r, base, slope;
        v   = int'($signed(x));
        mag = (v < 0) ? -v : v;
        if (mag > 127) mag = 127;
        if (m) begin
            r = mag * 4;
        end else begin
            seg  = mag / 32;
            frac = mag % 32;
            case (seg)
                0:       begin base = 0;     slope = 49912; end
                1:       begin base = 49912; slope = 13266; end
                2:       begin base = 63178; slope = 2034;  end
                default: begin base = 65212; slope = 280;   end
            endcase
            r = (base + (slope * frac) / 32 + 256) / 512;
        end
        if (r > 127) r = 127;
        return (v < 0) ? 8'(-r) : 8'(r);
    endfunction

    task automatic single(input logic [7:0] x, input logic m, input logic [7:0] exp, input string nm);
        @(posedge clk); #1;
        In = x; mode_i = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s early1: out_valid=%b required 0", nm, out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s early2: out_valid=%b required 0", nm, out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || Out1 !== exp) begin
            bad++;
            $display("FAIL %s: out_valid=%b Out1=%h required 1/%h", nm, out_valid, Out1, exp);
        end
    endtask

    // Streams s_in[0..n-1] at full rate, holding out_ready low for cycles [st, st+sl).
    task automatic run_stream(input int n, input int st, input int sl, input string nm);
        int  sent, got, cyc;
        logic ix, ox;
        sent = 0; got = 0; cyc = 0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; In = s_in[0]; mode_i = s_mode[0];
        while (got < n && cyc < n * 4 + 50) begin
            @(negedge clk);
            ix = in_valid & in_ready;
            ox = out_valid & out_ready;
            if (out_valid) begin
                total++;
                if (Out1 !== s_exp[got]) begin
                    bad++;
                    $display("FAIL %s[%0d]: Out1=%h required %h", nm, got, Out1, s_exp[got]);
                end
                if (ox) begin
                    cap[got] = Out1;
                    got++;
                end
            end
            if (cyc >= st && cyc < st + sl) begin
                total++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL %s stall cyc %0d: in_ready=%b out_valid=%b required 0/1",
                             nm, cyc, in_ready, out_valid);
                end
            end
            @(posedge clk); #1;
            if (ix) sent++;
            in_valid = (sent < n);
            if (sent < n) begin
                In = s_in[sent];
                mode_i = s_mode[sent];
            end
            cyc++;
            out_ready = !(cyc >= st && cyc < st + sl);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (got != n) begin
            bad++;
            $display("FAIL %s count: received=%0d required %0d", nm, got, n);
        end
        repeat (4) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL %s extra: out_valid=%b required 0", nm, out_valid);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: %b required 0", out_valid); end
        total++;
        if (Out1 !== 8'h00) begin bad++; $display("FAIL reset Out1: %h required 00", Out1); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready: %b required 1", in_ready); end
    endtask

    task automatic test_pwl_points();
        single(8'h00, 1'b0, 8'h00, "pwl_0");
        single(8'h20, 1'b0, 8'h61, "pwl_1p0");
        single(8'hE0, 1'b0, 8'h9F, "pwl_m1p0");
        single(8'h7F, 1'b0, 8'h7F, "pwl_max");
        single(8'h80, 1'b0, 8'h81, "pwl_min");
        single(8'h30, 1'b0, 8'h6E, "pwl_1p5");
    endtask

    task automatic test_hard_points();
        single(8'h10, 1'b1, 8'h40, "hard_0p5");
        single(8'hF0, 1'b1, 8'hC0, "hard_m0p5");
        single(8'h30, 1'b1, 8'h7F, "hard_clamp");
        single(8'hC0, 1'b1, 8'h81, "hard_mclamp");
    endtask

    task automatic test_back_to_back();
        logic [7:0] vi [10] = '{8'h00, 8'h20, 8'h10, 8'h7F, 8'hE0, 8'h30, 8'hF0, 8'h80, 8'h30, 8'hC0};
        logic       vm [10] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1};
        logic [7:0] ve [10] = '{8'h00, 8'h61, 8'h40, 8'h7F, 8'h9F, 8'h7F, 8'hC0, 8'h81, 8'h6E, 8'h81};
        for (int i = 0; i < 10; i++) begin
            s_in[i] = vi[i]; s_mode[i] = vm[i]; s_exp[i] = ve[i];
        end
        run_stream(10, 5, 4, "backpressure");
    endtask

    task automatic test_mode_interleave();
        for (int i = 0; i < 6; i++) begin
            s_in[i]   = 8'h30;
            s_mode[i] = i[0];
            s_exp[i]  = i[0] ? 8'h7F : 8'h6E;
        end
        run_stream(6, 0, 0, "interleave");
    endtask

    task automatic test_reset_midstream();
        @(posedge clk); #1;
        in_valid = 1'b1; In = 8'h20; mode_i = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1; In = 8'h10;
        @(posedge clk); #1; In = 8'h30;
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst inflight: out_valid=%b required 1", out_valid); end
        #1 reset_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || Out1 !== 8'h00) begin
            bad++;
            $display("FAIL midrst async: out_valid=%b Out1=%h required 0/00", out_valid, Out1);
        end
        @(posedge clk); @(posedge clk); #3 reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst in_ready: %b required 1", in_ready); end
        repeat (5) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst stale: out_valid=%b required 0", out_valid); end
        end
    endtask

    task automatic test_sweep(input logic m, input string nm);
        logic [7:0] na;
        for (int i = 0; i < 256; i++) begin
            s_in[i] = 8'(i); s_mode[i] = m; s_exp[i] = ref_tanh(8'(i), m);
        end
        run_stream(256, 0, 0, nm);
        for (int i = -127; i < 127; i++) begin
            total++;
            if ($signed(cap[8'(i + 1)]) < $signed(cap[8'(i)])) begin
                bad++;
                $display("FAIL %s monotonic at %0d: f=%h then %h required non-decreasing",
                         nm, i, cap[8'(i)], cap[8'(i + 1)]);
            end
        end
        for (int i = 1; i < 128; i++) begin
            na = -cap[i];
            total++;
            if (cap[256 - i] !== na) begin
                bad++;
                $display("FAIL %s symmetry at %0d: f(-x)=%h required %h", nm, i, cap[256 - i], na);
            end
        end
    endtask

`ifdef TANH_SAT_CNT_EN
    task automatic test_sat_cnt();
        @(posedge clk); #1 sat_clr = 1'b1;
        @(posedge clk); #1 sat_clr = 1'b0;
        @(negedge clk);
        total++;
        if (sat_cnt !== 16'd0) begin bad++; $display("FAIL sat_clr: sat_cnt=%0d required 0", sat_cnt); end
        single(8'h7F, 1'b0, 8'h7F, "sat_pwl");
        total++;
        if (sat_cnt !== 16'd1) begin bad++; $display("FAIL sat_pwl cnt: sat_cnt=%0d required 1", sat_cnt); end
        single(8'h20, 1'b0, 8'h61, "sat_none");
        total++;
        if (sat_cnt !== 16'd1) begin bad++; $display("FAIL sat_none cnt: sat_cnt=%0d required 1", sat_cnt); end
        single(8'h30, 1'b1, 8'h7F, "sat_hard");
        total++;
        if (sat_cnt !== 16'd2) begin bad++; $display("FAIL sat_hard cnt: sat_cnt=%0d required 2", sat_cnt); end
    endtask
`endif

    initial begin
        total = 0; bad = 0;
        reset_n = 1'b0; in_valid = 1'b0; In = 8'h00; mode_i = 1'b0; out_ready = 1'b1;
`ifdef TANH_SAT_CNT_EN
        sat_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        test_reset();
        test_pwl_points();
        test_hard_points();
        test_back_to_back();
        test_mode_interleave();
        test_reset_midstream();
        test_sweep(1'b0, "sweep_pwl");
        test_sweep(1'b1, "sweep_hard");
`ifdef TANH_SAT_CNT_EN
        test_sat_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
